// File: rtl/psg_io_port.sv
// Z80-side register file of the AY-3-8910 PSG with hand-controller readback on R14/R15.
// Register writes are forwarded to the sound core as a one-cycle strobe.
module psg_io_port #(
  parameter logic [7:0]  ADDR_PORT   = 8'hF7,
  parameter logic [7:0]  DATA_PORT   = 8'hF6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       io_rd,
  input  logic       io_wr,
  output logic [7:0] io_dout,
  output logic       io_dout_oe,
  input  logic [7:0] pad0_in,
  input  logic [7:0] pad1_in,
  output logic       psg_we,
  output logic [3:0] psg_reg,
  output logic [7:0] psg_data
);

  localparam int unsigned LastStage = SYNC_STAGES - 1;

  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  logic       rd_q, wr_q;
  logic [7:0] regs_q [16];
  logic [3:0] sel_q;
  logic       sel_ok_q;
  logic [7:0] pad0_sync_q [SYNC_STAGES];
  logic [7:0] pad1_sync_q [SYNC_STAGES];
  logic [7:0] dout_q;
  logic       oe_q;
  logic       we_q;
  logic [3:0] reg_q;
  logic [7:0] data_q;

  logic       rd_rise, wr_rise;
  logic       sel_wr, data_wr, data_rd;
  logic [7:0] wr_masked;
  logic [7:0] pad0_sync, pad1_sync;
  logic [7:0] read_val;

  // A strobe edge with both io_rd and io_wr high is not a valid access.
  assign rd_rise   = io_rd & ~rd_q & ~io_wr;
  assign wr_rise   = io_wr & ~wr_q & ~io_rd;
  assign sel_wr    = wr_rise & (io_addr == ADDR_PORT);
  assign data_wr   = wr_rise & (io_addr == DATA_PORT) & sel_ok_q;
  assign data_rd   = rd_rise & (io_addr == DATA_PORT);
  assign wr_masked = io_din & reg_mask(sel_q);
  assign pad0_sync = pad0_sync_q[LastStage];
  assign pad1_sync = pad1_sync_q[LastStage];

  always_comb begin
    read_val = regs_q[sel_q];
    if (!sel_ok_q) begin
      read_val = 8'hFF;
    end else if (sel_q == 4'd14 && !regs_q[7][6]) begin
      read_val = pad0_sync;
    end else if (sel_q == 4'd15 && !regs_q[7][7]) begin
      read_val = pad1_sync;
    end
  end

  always_ff @(posedge clk) begin
    // Strobe history keeps tracking during reset so a held strobe is not seen as a new edge.
    rd_q <= io_rd;
    wr_q <= io_wr;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 8'h00;
      end
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        pad0_sync_q[i] <= 8'hFF;
        pad1_sync_q[i] <= 8'hFF;
      end
      sel_q    <= 4'd0;
      sel_ok_q <= 1'b1;
      dout_q   <= 8'hFF;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      reg_q    <= 4'd0;
      data_q   <= 8'h00;
    end else begin
      pad0_sync_q[0] <= pad0_in;
      pad1_sync_q[0] <= pad1_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        pad0_sync_q[i] <= pad0_sync_q[i-1];
        pad1_sync_q[i] <= pad1_sync_q[i-1];
      end

      if (sel_wr) begin
        if (io_din[7:4] == 4'h0) begin
          sel_q    <= io_din[3:0];
          sel_ok_q <= 1'b1;
        end else begin
          sel_ok_q <= 1'b0;
        end
      end

      we_q <= data_wr;
      if (data_wr) begin
        regs_q[sel_q] <= wr_masked;
        reg_q         <= sel_q;
        data_q        <= wr_masked;
      end

      // Read data is a snapshot taken at the edge and held until io_rd falls.
      if (data_rd) begin
        oe_q   <= 1'b1;
        dout_q <= read_val;
      end else if (oe_q && !io_rd) begin
        oe_q   <= 1'b0;
        dout_q <= 8'hFF;
      end
    end
  end

  assign io_dout    = dout_q;
  assign io_dout_oe = oe_q;
  assign psg_we     = we_q;
  assign psg_reg    = reg_q;
  assign psg_data   = data_q;

endmodule

// File: tb/tb_psg_io_port.sv
// Directed bench for psg_io_port: select/data access, masking, pad readback,
// held strobes, bad select and reset during a read.
module tb_psg_io_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] io_addr = 8'h00;
  logic [7:0] io_din = 8'h00;
  logic       io_rd = 1'b0;
  logic       io_wr = 1'b0;
  logic [7:0] io_dout;
  logic       io_dout_oe;
  logic [7:0] pad0_in = 8'hFF;
  logic [7:0] pad1_in = 8'hFF;
  logic       psg_we;
  logic [3:0] psg_reg;
  logic [7:0] psg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;

  logic       last_we;
  logic [3:0] last_reg;
  logic [7:0] last_data;
  logic [7:0] rd_val;
  int         cnt0;

  psg_io_port #(
    .ADDR_PORT  (8'hF7),
    .DATA_PORT  (8'hF6),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_din    (io_din),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_dout   (io_dout),
    .io_dout_oe(io_dout_oe),
    .pad0_in   (pad0_in),
    .pad1_in   (pad1_in),
    .psg_we    (psg_we),
    .psg_reg   (psg_reg),
    .psg_data  (psg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (psg_we) we_count <= we_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a;
    io_din  = d;
    io_wr   = 1'b1;
    @(posedge clk);
    #1;
    last_we   = psg_we;
    last_reg  = psg_reg;
    last_data = psg_data;
    @(negedge clk);
    io_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, input string tag, output logic [7:0] d);
    @(negedge clk);
    io_addr = a;
    io_rd   = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_oe"}, io_dout_oe, 1);
    d = io_dout;
    @(negedge clk);
    io_rd = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_oe_off"}, io_dout_oe, 0);
    check({tag, "_idle"}, io_dout, 8'hFF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", io_dout, 8'hFF);
    check("rst_oe", io_dout_oe, 0);
    check("rst_we", psg_we, 0);
    check("rst_reg", psg_reg, 0);
    check("rst_data", psg_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1. idle pads, then pad0 pressed
    cnt0 = we_count;
    bus_write(8'hF7, 8'h0E);
    check("sel_no_we", we_count - cnt0, 0);
    bus_read(8'hF6, "t1a", rd_val);
    check("t1_idle_pad", rd_val, 8'hFF);
    pad0_in = 8'hBF;
    repeat (3) @(posedge clk);
    bus_read(8'hF6, "t1b", rd_val);
    check("t1_pad0", rd_val, 8'hBF);

    // 2. masking
    bus_write(8'hF7, 8'h01);
    bus_write(8'hF6, 8'hFF);
    check("t2_we", last_we, 1);
    check("t2_reg", last_reg, 4'd1);
    check("t2_data", last_data, 8'h0F);
    bus_read(8'hF6, "t2", rd_val);
    check("t2_rd", rd_val, 8'h0F);
    bus_write(8'hF7, 8'h08);
    bus_write(8'hF6, 8'hFF);
    check("t2_r8_data", last_data, 8'h1F);

    // 3. port A as output, port B still input
    bus_write(8'hF7, 8'h07);
    bus_write(8'hF6, 8'h40);
    check("t3_r7_reg", last_reg, 4'd7);
    check("t3_r7_data", last_data, 8'h40);
    pad0_in = 8'h00;
    pad1_in = 8'h3C;
    bus_write(8'hF7, 8'h0E);
    bus_write(8'hF6, 8'h55);
    repeat (3) @(posedge clk);
    bus_read(8'hF6, "t3a", rd_val);
    check("t3_r14_out", rd_val, 8'h55);
    bus_write(8'hF7, 8'h0F);
    bus_read(8'hF6, "t3b", rd_val);
    check("t3_r15_pad1", rd_val, 8'h3C);

    // 4. bad select drops data access
    bus_write(8'hF7, 8'h1E);
    cnt0 = we_count;
    bus_write(8'hF6, 8'h12);
    check("t4_no_we", we_count - cnt0, 0);
    bus_read(8'hF6, "t4a", rd_val);
    check("t4_rd_ff", rd_val, 8'hFF);
    bus_write(8'hF7, 8'h02);
    bus_write(8'hF6, 8'hAB);
    check("t4_we", last_we, 1);
    check("t4_reg", last_reg, 4'd2);
    check("t4_data", last_data, 8'hAB);
    bus_read(8'hF6, "t4b", rd_val);
    check("t4_rd", rd_val, 8'hAB);

    // 5a. io_wr held 10 clocks
    cnt0 = we_count;
    @(negedge clk);
    io_addr = 8'hF6;
    io_din  = 8'h33;
    io_wr   = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    io_wr = 1'b0;
    @(negedge clk);
    check("t5_held_wr_one_we", we_count - cnt0, 1);

    // 5b. pad change during a held read
    bus_write(8'hF7, 8'h07);
    bus_write(8'hF6, 8'h00);
    bus_write(8'hF7, 8'h0E);
    pad0_in = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    io_addr = 8'hF6;
    io_rd   = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rd_oe", io_dout_oe, 1);
    check("t5_rd_snap", io_dout, 8'h5A);
    @(negedge clk);
    pad0_in = 8'h11;
    repeat (4) @(posedge clk);
    #1;
    check("t5_rd_hold", io_dout, 8'h5A);
    check("t5_rd_hold_oe", io_dout_oe, 1);
    @(negedge clk);
    io_rd = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rd_release", io_dout_oe, 0);

    // 5c. io_rd and io_wr together
    cnt0 = we_count;
    @(negedge clk);
    io_din = 8'h77;
    io_rd  = 1'b1;
    io_wr  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_both_oe", io_dout_oe, 0);
    check("t5_both_we", we_count - cnt0, 0);
    @(negedge clk);
    io_rd = 1'b0;
    io_wr = 1'b0;
    @(negedge clk);

    // 6. reset during a read
    @(negedge clk);
    io_addr = 8'hF6;
    io_rd   = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rd_oe", io_dout_oe, 1);
    check("t6_rd_pad", io_dout, 8'h11);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_oe", io_dout_oe, 0);
    check("t6_rst_dout", io_dout, 8'hFF);
    check("t6_rst_we", psg_we, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_held_rd_no_access", io_dout_oe, 0);
    @(negedge clk);
    io_rd = 1'b0;
    @(negedge clk);
    bus_read(8'hF6, "t6a", rd_val);
    check("t6_r0_after_rst", rd_val, 8'h00);
    bus_write(8'hF7, 8'h01);
    bus_read(8'hF6, "t6b", rd_val);
    check("t6_r1_cleared", rd_val, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
